// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity constants and helper functions
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Widest payload supported; narrower payloads are zero-extended, which
  // leaves the XOR reduction unchanged.
  localparam int MAX_DATA_BITS = 9;

  // Clocks per oversample tick (integer division).
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

  // Parity bit a transmitter would send for the payload in the given mode.
  function automatic logic calc_parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                           input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick divider, phase reset by clear_i
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  // Next count: held at 0 while cleared, wraps after DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled UART receiver with valid/ready output register
module uart_rx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 rx_sync_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  import uart_pkg::*;

  localparam int DIV  = calc_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int OSW  = $clog2(OVERSAMPLE);
  localparam int HALF = OVERSAMPLE / 2;

  if (DIV < 1) begin : g_div_chk
    $error("uart_rx: CLK_FREQ_HZ too low for BAUD_RATE*OVERSAMPLE");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_os_chk
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > MAX_DATA_BITS)) begin : g_db_chk
    $error("uart_rx: DATA_BITS must be 5..9");
  end

  rx_state_t            state_q, state_d;
  logic [OSW-1:0]       os_cnt_q, os_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_err_q, stop_err_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 overrun_q, overrun_d;

  logic tick;
  logic os_full;

  // Tick phase restarts from the clock that detects the start edge.
  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (state_q == IDLE),
    .tick_o  (tick)
  );

  assign os_full = tick && (os_cnt_q == OSW'(OVERSAMPLE - 1));

  // Frame FSM: start detect, mid-bit sampling, parity and stop checks.
  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync_i) begin
          state_d  = START;
          os_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt_q == OSW'(HALF - 1)) begin
            os_cnt_d   = '0;
            bit_cnt_d  = '0;
            par_err_d  = 1'b0;
            stop_err_d = 1'b0;
            state_d    = rx_sync_i ? IDLE : DATA;
          end else begin
            os_cnt_d = os_cnt_q + OSW'(1);
          end
        end
      end
      DATA: begin
        if (os_full) begin
          os_cnt_d  = '0;
          shift_d   = {rx_sync_i, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          end
        end else if (tick) begin
          os_cnt_d = os_cnt_q + OSW'(1);
        end
      end
      uart_pkg::PARITY: begin
        if (os_full) begin
          os_cnt_d  = '0;
          par_err_d = calc_parity_bit(MAX_DATA_BITS'(shift_q), PARITY) != rx_sync_i;
          state_d   = STOP;
        end else if (tick) begin
          os_cnt_d = os_cnt_q + OSW'(1);
        end
      end
      STOP: begin
        if (os_full) begin
          os_cnt_d   = '0;
          done_d     = 1'b1;
          stop_err_d = !rx_sync_i;
          state_d    = rx_sync_i ? IDLE : BREAK_WAIT;
        end else if (tick) begin
          os_cnt_d = os_cnt_q + OSW'(1);
        end
      end
      BREAK_WAIT: begin
        if (rx_sync_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: load a finished frame unless the old one is still pending.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = 1'b0;
    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
    if (done_q) begin
      if (!rx_valid_q || rx_ready_i) begin
        rx_data_d  = shift_q;
        perr_out_d = par_err_q;
        ferr_out_d = stop_err_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign parity_err_o = perr_out_q;
  assign frame_err_o  = ferr_out_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx (8N1 and 8O1)
module tb_uart_rx;

  localparam int BIT_CLKS = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] rx;
  logic [1:0] rdy;
  logic [7:0] dout [2];
  logic       vld  [2];
  logic       perr [2];
  logic       ferr [2];
  logic       ovr  [2];
  logic       bsy  [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc [2];
  int rise_cyc  [2];
  int vcyc      [2];
  int ovr_cnt   [2];
  int busy_cnt;
  logic prev_vld [2];
  logic [9:0] obs0 [$];
  logic [9:0] obs1 [$];

  uart_rx #(
    .CLK_FREQ_HZ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0)
  ) u_dut_8n1 (
    .clk_i(clk), .rst_n_i(rst_n), .rx_sync_i(rx[0]), .rx_data_o(dout[0]),
    .rx_valid_o(vld[0]), .rx_ready_i(rdy[0]), .parity_err_o(perr[0]),
    .frame_err_o(ferr[0]), .overrun_o(ovr[0]), .busy_o(bsy[0])
  );

  uart_rx #(
    .CLK_FREQ_HZ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2)
  ) u_dut_8o1 (
    .clk_i(clk), .rst_n_i(rst_n), .rx_sync_i(rx[1]), .rx_data_o(dout[1]),
    .rx_valid_o(vld[1]), .rx_ready_i(rdy[1]), .parity_err_o(perr[1]),
    .frame_err_o(ferr[1]), .overrun_o(ovr[1]), .busy_o(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observe outputs mid-cycle: accepted payloads, valid rises, pulses, busy.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (vld[i]) vcyc[i]++;
      if (vld[i] && !prev_vld[i]) rise_cyc[i] = cyc;
      if (ovr[i]) ovr_cnt[i]++;
      if (vld[i] && rdy[i]) begin
        if (i == 0) obs0.push_back({ferr[i], perr[i], dout[i]});
        else        obs1.push_back({ferr[i], perr[i], dout[i]});
      end
      prev_vld[i] = vld[i];
    end
    if (bsy[0]) busy_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                            input bit pb, input bit stop);
    start_cyc[sel] = cyc;
    rx[sel] = 1'b0;
    step(BIT_CLKS);
    for (int b = 0; b < 8; b++) begin
      rx[sel] = d[b];
      step(BIT_CLKS);
    end
    if (use_par) begin
      rx[sel] = pb;
      step(BIT_CLKS);
    end
    rx[sel] = stop;
    step(BIT_CLKS);
    rx[sel] = 1'b1;
  endtask

  // Reference: odd parity is violated when total ones (data + parity) is even.
  function automatic logic [9:0] model_frame(input logic [7:0] d, input bit use_par,
                                             input bit pb, input bit stop);
    logic pe;
    pe = use_par ? ((($countones(d) + int'(pb)) % 2) == 0) : 1'b0;
    return {~stop, pe, d};
  endfunction

  task automatic check_outputs_zero(input int i, input string pfx);
    check({pfx, "_data"}, dout[i], 0);
    check({pfx, "_valid"}, vld[i], 0);
    check({pfx, "_perr"}, perr[i], 0);
    check({pfx, "_ferr"}, ferr[i], 0);
    check({pfx, "_ovr"}, ovr[i], 0);
    check({pfx, "_busy"}, bsy[i], 0);
  endtask

  initial begin
    logic [7:0] d;
    bit pb;
    logic [9:0] exp_q [$];
    int lat;

    for (int i = 0; i < 2; i++) begin
      start_cyc[i] = 0; rise_cyc[i] = 0; vcyc[i] = 0; ovr_cnt[i] = 0; prev_vld[i] = 1'b0;
    end
    busy_cnt = 0;
    rx = 2'b11;
    rdy = 2'b11;
    rst_n = 1'b0;
    step(3);
    check_outputs_zero(0, "rst0");
    check_outputs_zero(1, "rst1");
    rst_n = 1'b1;
    step(4);

    // 0xA5 8N1 with ready high: one-cycle valid, latency ~153 from detection.
    vcyc[0] = 0;
    obs0.delete();
    send_frame(0, 8'hA5, 0, 0, 1);
    step(4);
    lat = rise_cyc[0] - start_cyc[0] - 1;
    check("a5_count", obs0.size(), 1);
    if (obs0.size() > 0) check("a5_payload", obs0[0], model_frame(8'hA5, 0, 0, 1));
    check("a5_valid_cycles", vcyc[0], 1);
    check("a5_latency_in_152_154", int'(lat >= 152 && lat <= 154), 1);
    if (lat < 152 || lat > 154) $display("latency observed %0d", lat);

    // 5-clock glitch: false start, no payload, short busy.
    vcyc[0] = 0;
    busy_cnt = 0;
    rx[0] = 1'b0;
    step(5);
    rx[0] = 1'b1;
    step(30);
    check("glitch_valid_cycles", vcyc[0], 0);
    check("glitch_busy_le9", int'(busy_cnt <= 9 && busy_cnt > 0), 1);
    check("glitch_idle", bsy[0], 0);

    // Odd parity: 0x3C with parity 0 (error), then parity 1 (clean).
    for (int k = 0; k < 2; k++) begin
      obs1.delete();
      pb = (k == 1);
      send_frame(1, 8'h3C, 1, pb, 1);
      step(4);
      check("odd3c_count", obs1.size(), 1);
      if (obs1.size() > 0) check("odd3c_payload", obs1[0], model_frame(8'h3C, 1, pb, 1));
    end

    // Break: 0x55 with stop 0, line held low 40 bits, then 0x12.
    obs0.delete();
    send_frame(0, 8'h55, 0, 0, 0);
    rx[0] = 1'b0;
    step(40 * BIT_CLKS);
    rx[0] = 1'b1;
    step(2 * BIT_CLKS);
    send_frame(0, 8'h12, 0, 0, 1);
    step(4);
    check("break_count", obs0.size(), 2);
    if (obs0.size() > 1) begin
      check("break_payload", obs0[0], model_frame(8'h55, 0, 0, 0));
      check("after_break_payload", obs0[1], model_frame(8'h12, 0, 0, 1));
    end

    // Overrun: ready low, 0x11 then 0x22; 0x11 is kept, one overrun pulse.
    obs0.delete();
    ovr_cnt[0] = 0;
    rdy[0] = 1'b0;
    send_frame(0, 8'h11, 0, 0, 1);
    send_frame(0, 8'h22, 0, 0, 1);
    step(4);
    check("ovr_valid_held", vld[0], 1);
    check("ovr_data_kept", dout[0], 8'h11);
    check("ovr_pulses", ovr_cnt[0], 1);
    rdy[0] = 1'b1;
    step(2);
    check("ovr_valid_drop", vld[0], 0);
    check("ovr_accept_count", obs0.size(), 1);
    if (obs0.size() > 0) check("ovr_accept_payload", obs0[0], model_frame(8'h11, 0, 0, 1));

    // Reset during data bit 4 of 0xFF, then 0x81 must arrive clean.
    obs0.delete();
    rx[0] = 1'b0;
    step(BIT_CLKS);
    rx[0] = 1'b1;
    step(4 * BIT_CLKS + 8);
    rst_n = 1'b0;
    step(2);
    check_outputs_zero(0, "midrst");
    rst_n = 1'b1;
    step(20);
    send_frame(0, 8'h81, 0, 0, 1);
    step(4);
    check("midrst_count", obs0.size(), 1);
    if (obs0.size() > 0) check("midrst_payload", obs0[0], model_frame(8'h81, 0, 0, 1));

    // Randomized frames on both receivers against the reference model.
    obs0.delete();
    obs1.delete();
    exp_q.delete();
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(model_frame(d, 0, 0, 1));
      send_frame(0, d, 0, 0, 1);
      step($urandom_range(1, 20));
    end
    check("rand8n1_count", obs0.size(), 8);
    for (int n = 0; n < 8 && n < obs0.size(); n++) check("rand8n1_payload", obs0[n], exp_q[n]);
    exp_q.delete();
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      exp_q.push_back(model_frame(d, 1, pb, 1));
      send_frame(1, d, 1, pb, 1);
      step($urandom_range(1, 20));
    end
    check("rand8o1_count", obs1.size(), 8);
    for (int n = 0; n < 8 && n < obs1.size(); n++) check("rand8o1_payload", obs1[n], exp_q[n]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
